// File: rtl/vga_framebuffer.sv
// 160x120x3 framebuffer written over the game's pixel bus and scanned out as 640x480@60 VGA,
// each stored pixel replicated 4x4. Memory is cleared to BG_COLOUR after every reset.
module vga_framebuffer #(
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] colour,
    input  logic       writeEn,
    output logic       busy,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);
    // state   | meaning
    // CLEAR   | writing BG_COLOUR to clr_addr, external writes dropped
    // RUN     | external writes accepted
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam int unsigned MEM_DEPTH = 19200;

    logic [0:0]  state;
    logic [14:0] clr_addr;
    logic        pix_ph;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;

    logic [2:0]  mem [0:MEM_DEPTH-1];
    logic [2:0]  rd_data;
    logic [14:0] rd_addr;
    logic [14:0] wr_addr;
    logic        ext_we;
    logic        mem_we;
    logic [14:0] mem_wa;
    logic [2:0]  mem_wd;

    logic        hs_c, vs_c, vis_c;
    logic        hs_d, vs_d, vis_d;

    assign busy       = (state == S_CLEAR);
    assign VGA_CLK    = pix_ph;
    assign VGA_SYNC_N = 1'b1;

    // row*160 + col as row*128 + row*32 + col
    assign rd_addr = {v_cnt[9:2], 7'b0} + {2'b0, v_cnt[9:2], 5'b0} + {7'b0, h_cnt[9:2]};
    assign wr_addr = {1'b0, y[6:0], 7'b0} + {3'b0, y[6:0], 5'b0} + {7'b0, x[7:0]};

    assign ext_we = writeEn && (x < 10'd160) && (y < 10'd120);
    assign mem_we = resetn && (busy || ext_we);
    assign mem_wa = busy ? clr_addr : wr_addr;
    assign mem_wd = busy ? BG_COLOUR : colour;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_addr == 15'(MEM_DEPTH - 1)) begin
                        state <= S_RUN;
                    end else begin
                        clr_addr <= clr_addr + 15'd1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read-first: a same-edge write to rd_addr is seen on a later frame.
    always_ff @(posedge clk) begin
        if (pix_ph) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_ph <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_ph <= ~pix_ph;
            if (pix_ph) begin
                if (h_cnt == 10'd799) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    assign hs_c  = !((h_cnt >= 10'd656) && (h_cnt < 10'd752));
    assign vs_c  = !((v_cnt >= 10'd490) && (v_cnt < 10'd492));
    assign vis_c = (h_cnt < 10'd640) && (v_cnt < 10'd480);

    // Sync/visible travel alongside the memory read so pins stay aligned with data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            vis_d       <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_ph) begin
            hs_d        <= hs_c;
            vs_d        <= vs_c;
            vis_d       <= vis_c;
            VGA_HS      <= hs_d;
            VGA_VS      <= vs_d;
            VGA_BLANK_N <= vis_d;
            VGA_R       <= (vis_d && rd_data[2]) ? 10'h3FF : 10'h000;
            VGA_G       <= (vis_d && rd_data[1]) ? 10'h3FF : 10'h000;
            VGA_B       <= (vis_d && rd_data[0]) ? 10'h3FF : 10'h000;
        end
    end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Scoreboard bench for vga_framebuffer: a timing/memory model queues the expected pin state
// every clk and a monitor on the falling edge pops and compares it.
module tb_vga_framebuffer;
    logic       clk = 1'b0;
    logic       resetn;
    logic [9:0] x, y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0] VGA_R, VGA_G, VGA_B;

    vga_framebuffer #(.BG_COLOUR(3'b000)) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .busy(busy), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       clk_o;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       busy;
        logic [2:0] rgb;
        logic       chk_rgb;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    want;
    } meas_t;

    exp_t  exp_q[$];
    meas_t meas_q[$];
    logic [2:0] mem_m [0:119][0:159];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // Pins after clk edge e reflect the scan counters at pixel tick e/2-2.
    function automatic exp_t expected(input int e);
        exp_t r;
        int t, h, v;
        r = '0;
        r.clk_o = e[0];
        r.busy  = (e < 19200);
        t = e / 2 - 2;
        if (t < 0) begin
            r.hs = 1'b1;
            r.vs = 1'b1;
            r.chk_rgb = 1'b1;
        end else begin
            h = t % 800;
            v = (t / 800) % 525;
            r.blank = (h < 640) && (v < 480);
            r.hs = !((h >= 656) && (h < 752));
            r.vs = !((v >= 490) && (v < 492));
            // memory is fully defined only once the clear has finished
            r.chk_rgb = !r.blank || (t >= 9600);
            if (r.blank) r.rgb = mem_m[v / 4][h / 4];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!resetn) cyc = 0;
        else cyc = cyc + 1;
        exp_q.push_back(expected(cyc));
        if (resetn && writeEn && cyc > 19200 && x < 160 && y < 120) mem_m[y][x] = colour;
    end

    always @(negedge clk) begin
        exp_t  xe;
        meas_t m;
        if (exp_q.size() > 0) begin
            xe = exp_q.pop_front();
            n_chk++;
            if ({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, busy, VGA_SYNC_N} !==
                {xe.clk_o, xe.hs, xe.vs, xe.blank, xe.busy, 1'b1}) begin
                n_fail++;
                $display("FAIL timing cyc=%0d clk/hs/vs/blank/busy/sync got %b%b%b%b%b%b want %b%b%b%b%b1",
                         cyc, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, busy, VGA_SYNC_N,
                         xe.clk_o, xe.hs, xe.vs, xe.blank, xe.busy);
            end
            if (xe.chk_rgb) begin
                n_chk++;
                if (VGA_R !== {10{xe.rgb[2]}} || VGA_G !== {10{xe.rgb[1]}} || VGA_B !== {10{xe.rgb[0]}}) begin
                    n_fail++;
                    $display("FAIL rgb cyc=%0d got R=%h G=%h B=%h want colour %b",
                             cyc, VGA_R, VGA_G, VGA_B, xe.rgb);
                end
            end
        end
        while (meas_q.size() > 0) begin
            m = meas_q.pop_front();
            n_chk++;
            if (m.got != m.want) begin
                n_fail++;
                $display("FAIL %s got %0d want %0d", m.name, m.got, m.want);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wr(input int px, input int py, input logic [2:0] c);
        x = 10'(px);
        y = 10'(py);
        colour = c;
        writeEn = 1'b1;
        @(negedge clk);
        writeEn = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++)
                mem_m[r][c] = 3'b000;
        resetn = 1'b0;
        writeEn = 1'b0;
        x = '0;
        y = '0;
        colour = '0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;

        wait_cyc(100);
        wr(2, 4, 3'b010);

        // one-clk reset in the middle of the clear
        wait_cyc(10000);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        begin
            int k = 0;
            while (VGA_HS !== 1'b0 && k < 5000) begin
                @(negedge clk);
                k++;
            end
            meas_q.push_back('{"hs_first_fall", (VGA_HS === 1'b0) ? cyc : -1, 1316});
        end

        wait_cyc(2000);
        wr(2, 4, 3'b010);

        begin
            int k = 0;
            while (busy !== 1'b0 && k < 30000) begin
                @(negedge clk);
                k++;
            end
            meas_q.push_back('{"clear_length", (busy === 1'b0) ? cyc : -1, 19200});
        end

        wr(5, 4, 3'b100);
        wr(6, 4, 3'b001);
        wr(7, 5, 3'b011);
        wr(159, 6, 3'b111);
        wr(0, 6, 3'b110);
        wr(160, 3, 3'b111);
        wr(320, 2, 3'b111);
        wr(0, 120, 3'b111);
        wr(1023, 1023, 3'b111);

        // scan through pixel row 6 (lines 24..27)
        wait_cyc(2 * (28 * 800 + 2) + 2);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_framebuffer.md
Name: vga_framebuffer

Overview:
- Pixel sink at the far end of the game's pixel-write bus (x, y, colour, writeEn), as driven by the draw multiplexer.
- Stores writes in an on-chip 160x120x3-bit framebuffer and scans it out continuously as 640x480@60 Hz VGA, each stored pixel replicated 4x4.
- Clears the framebuffer to a background colour after reset.
- Replaces the external VGA adapter inside the top-level draw wrapper.

Parameters:
- BG_COLOUR, 3'b000, colour written to every location during post-reset clear.

Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  synchronous, active-low reset
- x  in  10  write column, valid 0..159
- y  in  10  write row, valid 0..119
- colour  in  3  {R,G,B} write colour
- writeEn  in  1  write strobe, one pixel per clk while high
- busy  out  1  high while post-reset clear runs; writes dropped
- VGA_CLK  out  1  25 MHz pixel clock
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high in visible region only
- VGA_SYNC_N  out  1  constant 1
- VGA_R  out  10  red
- VGA_G  out  10  green
- VGA_B  out  10  blue

Behaviour:
- Reset is decided as follows: resetn is synchronous and active-low; the clock is clk.
- Reset values:
  - pix_ph=0, h_cnt=0, v_cnt=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
  - busy=1, clr_addr=0.
- Pixel tick:
  - pix_ph toggles every clk, and VGA_CLK=pix_ph.
  - Scan state advances only on clk edges where pix_ph==1, so pin outputs change as VGA_CLK falls.
- Horizontal timing: h_cnt counts 0..799 and wraps to 0.
  - Visible h<640.
  - Sync low for 656<=h<752.
- Vertical timing: v_cnt increments when h_cnt wraps; counts 0..524 and wraps to 0.
  - Visible v<480.
  - Sync low for 490<=v<492.
- Read address: rd_addr = (v_cnt>>2)*160 + (h_cnt>>2), computed with shifts/adds (y*128+y*32+x), no multiplier.
- Scan pipeline, per pixel tick:
  - Stage 1: registered memory read; HS/VS/visible delayed one tick alongside it.
  - Stage 2: output registers.
  - Pins at tick n reflect counters at tick n-2, with data and sync aligned.
- Colour expansion:
  - VGA_R = colour[2] ? 10'h3FF : 0; G uses bit 1; B uses bit 0.
  - All three are 0 when BLANK_N=0.
- Write port:
  - Memory is written on the same clk edge where writeEn=1 && busy=0 && x<160 && y<120.
  - Write address is y*160+x.
  - Out-of-range writes are ignored. There is no wrap, so x=160,y=0 must not alias to (0,1).
- Write/read same address in the same clk: the read returns the old data (read-first). A write is visible to scanout no later than the next frame.
- Clear FSM:
  - States: CLEAR, RUN.
  - In CLEAR, one location is written with BG_COLOUR per clk for clr_addr 0..19199.
  - After the write of 19199 the FSM goes to RUN, and busy=0 from the following clk.
  - Clear takes exactly 19200 clks from reset release.
- During CLEAR:
  - External writes are dropped and not queued.
  - Scanout keeps running with normal timing and shows memory contents.
- Reset asserted mid-clear or mid-frame restarts everything: clear from address 0, counters to 0.

Test Plan:
- Clear timing: release resetn, count clks until busy=0 -> exactly 19200; then scan a full frame -> every visible pixel RGB=0 (BG_COLOUR=000).
- Single write: after busy=0, write (5,3)=3'b100, wait 2 frames -> for v 12..15, h 20..23: VGA_R=10'h3FF, G=B=0; neighbours (h 19, h 24) show 0.
- Sync timing: measure at pins -> HS low 96 pixel ticks every 800; VS low 2 lines (1600 ticks) every 525 lines; BLANK_N high 640 ticks per line on 480 lines; VGA_SYNC_N=1 throughout.
- Bounds and alias: write x=160,y=0 colour 3'b111, then x=0,y=120 -> pixel (0,1) and all of row 0 remain 0; no change anywhere in the frame.
- Busy drop: write (0,0)=3'b010 during CLEAR, then wait 1 frame after busy=0 -> pixel (0,0) still shows 0.
- Reset mid-operation: assert resetn=0 for 1 clk at clear address 10000 -> busy stays 1 for a further 19200 clks; assert at h=300 -> HS/VS restart with the first HS low edge 656+2 ticks after reset release.
